// File: rtl/ehl_gpio_pkg.sv
// Shared constants and helpers for the GPIO input conditioning path.
package ehl_gpio_pkg;

    localparam int EHL_GPIO_FLT_CNT_W_DEF = 4;
    localparam int EHL_GPIO_PRESC_W_DEF   = 8;

    // Returns {rise, fall} for a level moving from q to q_next.
    function automatic logic [1:0] ehl_gpio_edge(input logic q, input logic q_next);
        return {q_next & ~q, ~q_next & q};
    endfunction

endpackage

// File: rtl/ehl_gpio_in_filter_bit.sv
// One GPIO line: optional 2-flop synchroniser (EHL_GPIO_IN_FILTER_SYNC_EN),
// glitch-filter counter, filtered level and registered edge pulses.
module ehl_gpio_in_filter_bit
    import ehl_gpio_pkg::*;
#(
    parameter int   CNT_WIDTH = EHL_GPIO_FLT_CNT_W_DEF,
    parameter logic INIT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pad,
    input  logic                 ena,
    input  logic [CNT_WIDTH-1:0] threshold,
    input  logic                 tick,
    output logic                 q,
    output logic                 rise,
    output logic                 fall
);

    logic                 s;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 q_next;
    logic [1:0]           edge_next;

`ifdef EHL_GPIO_IN_FILTER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {2{INIT}};
        end else begin
            sync_q <= {sync_q[0], pad};
        end
    end

    assign s = sync_q[1];
`else
    assign s = pad;
`endif

    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        if (!ena || threshold == '0) begin
            q_next   = s;
            cnt_next = '0;
        end else if (s == q) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt == threshold - CNT_WIDTH'(1)) begin
                q_next   = s;
                cnt_next = '0;
            end else if (cnt >= threshold) begin
                // Threshold was lowered under a running count: restart without a level change.
                cnt_next = '0;
            end else begin
                cnt_next = cnt + CNT_WIDTH'(1);
            end
        end
        edge_next = ehl_gpio_edge(q, q_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= INIT;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            q    <= q_next;
            cnt  <= cnt_next;
            rise <= edge_next[1];
            fall <= edge_next[0];
        end
    end

endmodule

// File: rtl/ehl_gpio_in_filter.sv
// GPIO input conditioning: shared tick prescaler plus WIDTH per-bit filters.
// Define EHL_GPIO_IN_FILTER_SYNC_EN to add a 2-flop synchroniser on every pad.
module ehl_gpio_in_filter
    import ehl_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               CNT_WIDTH   = EHL_GPIO_FLT_CNT_W_DEF,
    parameter int               PRESC_WIDTH = EHL_GPIO_PRESC_W_DEF,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       pad_in,
    input  logic [WIDTH-1:0]       flt_ena,
    input  logic [CNT_WIDTH-1:0]   threshold,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic [WIDTH-1:0]       gpio_in,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] pcnt;

    // Comparing with >= lets a lowered presc wrap immediately instead of stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt >= presc) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + PRESC_WIDTH'(1);
            tick <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        ehl_gpio_in_filter_bit #(
            .CNT_WIDTH (CNT_WIDTH),
            .INIT      (INIT[gi])
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .pad       (pad_in[gi]),
            .ena       (flt_ena[gi]),
            .threshold (threshold),
            .tick      (tick),
            .q         (gpio_in[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

endmodule
